// File: rtl/bloom_probe_sched_pkg.sv
// Shared types, default sizes and probe field helpers for the Bloom filter
// probe scheduler. A probe is packed as {word_addr, bit_sel}.
package bloom_pkg;

    typedef enum logic [2:0] {
        IDLE,
        Q_RD,
        Q_LAST,
        INS_RD,
        INS_WR,
        CLEAR,
        RESP
    } bloom_sched_state_t;

    typedef enum logic {
        GNT_QUERY,
        GNT_INSERT
    } bloom_grant_t;

    // Which operation the RESP state is finishing.
    typedef enum logic [1:0] {
        OP_QUERY,
        OP_INSERT,
        OP_CLEAR
    } bloom_op_t;

    localparam int DEF_HASH_COUNT = 3;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;

    // Word address of a probe; the caller narrows the result to ADDR_WIDTH.
    function automatic logic [31:0] probe_word(input logic [31:0] probe, input int bit_w);
        return probe >> bit_w;
    endfunction

    // Bit select of a probe; the caller narrows the result to BIT_W.
    function automatic logic [31:0] probe_bit(input logic [31:0] probe, input int bit_w);
        return probe & ((32'd1 << bit_w) - 32'd1);
    endfunction

endpackage

// File: rtl/bloom_probe_sched_if.sv
// Request/response and BRAM signals of the probe scheduler.
// master: requesters plus BRAM side; slave: the scheduler itself.
interface bloom_probe_sched_if
    import bloom_pkg::*;
#(
    parameter int HASH_COUNT = DEF_HASH_COUNT,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam int PW    = ADDR_WIDTH + BIT_W;

    logic                       q_valid;
    logic                       q_ready;
    logic [HASH_COUNT*PW-1:0]   q_probes;
    logic                       q_resp_valid;
    logic                       q_hit;

    logic                       ins_valid;
    logic                       ins_ready;
    logic [HASH_COUNT*PW-1:0]   ins_probes;
    logic                       ins_done;

    logic                       clr_req;
    logic                       clr_busy;
    logic                       clr_done;

    logic                       mem_en;
    logic                       mem_we;
    logic [ADDR_WIDTH-1:0]      mem_addr;
    logic [DATA_WIDTH-1:0]      mem_wdata;
    logic [DATA_WIDTH-1:0]      mem_rdata;

    modport master (
        output q_valid, q_probes, ins_valid, ins_probes, clr_req, mem_rdata,
        input  q_ready, q_resp_valid, q_hit, ins_ready, ins_done,
               clr_busy, clr_done, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  q_valid, q_probes, ins_valid, ins_probes, clr_req, mem_rdata,
        output q_ready, q_resp_valid, q_hit, ins_ready, ins_done,
               clr_busy, clr_done, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/bloom_probe_sched_rr_arb2.sv
// Two-way round-robin arbiter between query and insert. The last grant is
// registered and only moves when the granted request is actually accepted.
module rr_arb2
    import bloom_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         req_q_i,
    input  logic         req_ins_i,
    input  logic         accept_i,
    output bloom_grant_t gnt_o
);

    bloom_grant_t last_q;
    bloom_grant_t last_d;

    // A lone requester wins outright; otherwise the side not granted last.
    always_comb begin
        if (req_q_i && !req_ins_i) begin
            gnt_o = GNT_QUERY;
        end else if (req_ins_i && !req_q_i) begin
            gnt_o = GNT_INSERT;
        end else if (last_q == GNT_INSERT) begin
            gnt_o = GNT_QUERY;
        end else begin
            gnt_o = GNT_INSERT;
        end
    end

    // Remember the winner of each accepted request.
    always_comb begin
        last_d = last_q;
        if (accept_i) begin
            last_d = gnt_o;
        end
    end

    // Last-grant register; starts at INSERT so the query wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= GNT_INSERT;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/bloom_probe_sched.sv
// Bloom filter bit-array scheduler: arbitrates query, insert and clear onto
// one single-port BRAM. Queries read HASH_COUNT probes back to back, inserts
// read-modify-write each probe in turn, clear zeroes every word.
// Optional feature macro: BLOOM_EARLY_EXIT_EN (query stops at first 0 bit).
module bloom_probe_sched
    import bloom_pkg::*;
#(
    parameter int HASH_COUNT = DEF_HASH_COUNT,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
)(
    input  logic                clk,
    input  logic                rst,
    bloom_probe_sched_if.slave  bus
);

    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam int PW    = ADDR_WIDTH + BIT_W;
    localparam int IDX_W = (HASH_COUNT > 1) ? $clog2(HASH_COUNT) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(HASH_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
`ifdef BLOOM_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    bloom_sched_state_t         state_q, state_d;
    bloom_op_t                  op_q, op_d;
    logic [HASH_COUNT*PW-1:0]   probes_q, probes_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]      clr_cnt_q, clr_cnt_d;
    logic                       hit_q, hit_d;
    logic [BIT_W-1:0]           prev_bit_q, prev_bit_d;
    logic                       prev_vld_q, prev_vld_d;

    logic [PW-1:0]              probe_arr [HASH_COUNT];
    logic [ADDR_WIDTH-1:0]      cur_word;
    logic [BIT_W-1:0]           cur_bit;
    logic [DATA_WIDTH-1:0]      bit_mask;
    logic                       sampled_bit;
    bloom_grant_t               gnt;
    logic                       arb_open;
    logic                       q_acc;
    logic                       ins_acc;
    logic                       resp;

    // Unpack the captured probe vector into one entry per hash.
    for (genvar gi = 0; gi < HASH_COUNT; gi++) begin : g_probe
        assign probe_arr[gi] = probes_q[gi*PW +: PW];
    end

    assign cur_word    = ADDR_WIDTH'(probe_word(32'(probe_arr[idx_q]), BIT_W));
    assign cur_bit     = BIT_W'(probe_bit(32'(probe_arr[idx_q]), BIT_W));
    assign bit_mask    = DATA_WIDTH'(1) << cur_bit;
    // Bit of the probe whose read was issued in the previous cycle.
    assign sampled_bit = bus.mem_rdata[prev_bit_q];

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_q_i   (bus.q_valid),
        .req_ins_i (bus.ins_valid),
        .accept_i  (q_acc || ins_acc),
        .gnt_o     (gnt)
    );

    // Readiness is gated by reset so every output reads 0 while rst is high.
    assign arb_open      = (state_q == IDLE) && !rst && !bus.clr_req;
    assign bus.q_ready   = arb_open && (gnt == GNT_QUERY);
    assign bus.ins_ready = arb_open && (gnt == GNT_INSERT);
    assign q_acc         = bus.q_valid && bus.q_ready;
    assign ins_acc       = bus.ins_valid && bus.ins_ready;

    assign resp             = (state_q == RESP);
    assign bus.q_resp_valid = resp && (op_q == OP_QUERY);
    assign bus.q_hit        = resp && (op_q == OP_QUERY) && hit_q;
    assign bus.ins_done     = resp && (op_q == OP_INSERT);
    assign bus.clr_done     = resp && (op_q == OP_CLEAR);
    assign bus.clr_busy     = (state_q == CLEAR);

    // Next-state logic: arbitration, probe stepping and hit accumulation.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        probes_d   = probes_q;
        idx_d      = idx_q;
        clr_cnt_d  = clr_cnt_q;
        hit_d      = hit_q;
        prev_bit_d = cur_bit;
        prev_vld_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d   = CLEAR;
                    op_d      = OP_CLEAR;
                    clr_cnt_d = '0;
                end else if (q_acc) begin
                    state_d  = Q_RD;
                    op_d     = OP_QUERY;
                    probes_d = bus.q_probes;
                    idx_d    = '0;
                    hit_d    = 1'b1;
                end else if (ins_acc) begin
                    state_d  = INS_RD;
                    op_d     = OP_INSERT;
                    probes_d = bus.ins_probes;
                    idx_d    = '0;
                end
            end
            Q_RD: begin
                prev_vld_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = Q_LAST;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            Q_LAST: state_d = RESP;
            INS_RD: state_d = INS_WR;
            INS_WR: begin
                if (idx_q == LAST_IDX) begin
                    state_d = RESP;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = INS_RD;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = RESP;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Read data of a query probe arrives one cycle after its read.
        if (prev_vld_q) begin
            hit_d = hit_q & sampled_bit;
            if (EARLY_EXIT && !sampled_bit) begin
                state_d    = RESP;
                prev_vld_d = 1'b0;
            end
        end
    end

    // BRAM port drive; everything is held at 0 when the port is idle.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            Q_RD, INS_RD: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = cur_word;
            end
            INS_WR: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = cur_word;
                bus.mem_wdata = bus.mem_rdata | bit_mask;
            end
            CLEAR: begin
                bus.mem_en   = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = clr_cnt_q;
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= OP_QUERY;
            probes_q   <= '0;
            idx_q      <= '0;
            clr_cnt_q  <= '0;
            hit_q      <= 1'b0;
            prev_bit_q <= '0;
            prev_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            probes_q   <= probes_d;
            idx_q      <= idx_d;
            clr_cnt_q  <= clr_cnt_d;
            hit_q      <= hit_d;
            prev_bit_q <= prev_bit_d;
            prev_vld_q <= prev_vld_d;
        end
    end

endmodule

// File: tb/tb_bloom_probe_sched.sv
// Self-checking bench for bloom_probe_sched: BRAM model, bit-level
// reference array, directed scenarios then random query/insert/clear.
module tb_bloom_probe_sched;

    localparam int H  = 3;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int BW = 4;
    localparam int PW = AW + BW;
    localparam int NW = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bloom_probe_sched_if #(.HASH_COUNT(H), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bloom_probe_sched #(.HASH_COUNT(H), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single-port BRAM with one-cycle registered read.
    logic [DW-1:0] bram [NW];
    logic [DW-1:0] rdata_r = '0;
    assign bus.mem_rdata = rdata_r;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
            else            rdata_r <= bram[bus.mem_addr];
        end
    end

    // Bus monitors.
    int bus_idle_viol = 0;
    int clr_writes    = 0;
    always @(posedge clk) begin
        if (!bus.mem_en && (bus.mem_we || bus.mem_addr != '0 || bus.mem_wdata != '0))
            bus_idle_viol++;
        if (bus.mem_en && bus.mem_we && bus.clr_busy)
            clr_writes++;
    end

    // Reference bit array.
    logic [DW-1:0] ref_mem [NW];

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pword(input logic [H*PW-1:0] p, input int i);
        logic [PW-1:0] e;
        e = p[i*PW +: PW];
        return int'(e[PW-1:BW]);
    endfunction

    function automatic int pbit(input logic [H*PW-1:0] p, input int i);
        logic [PW-1:0] e;
        e = p[i*PW +: PW];
        return int'(e[BW-1:0]);
    endfunction

    function automatic logic [H*PW-1:0] mk3(input int w0, input int b0, input int w1,
                                            input int b1, input int w2, input int b2);
        logic [H*PW-1:0] r;
        r[0 +: PW]    = {AW'(w0), BW'(b0)};
        r[PW +: PW]   = {AW'(w1), BW'(b1)};
        r[2*PW +: PW] = {AW'(w2), BW'(b2)};
        return r;
    endfunction

    function automatic logic [H*PW-1:0] rand_probes();
        logic [H*PW-1:0] r;
        for (int i = 0; i < H; i++)
            r[i*PW +: PW] = {AW'($urandom_range(0, 15)), BW'($urandom_range(0, 15))};
        return r;
    endfunction

    // Query hits when every probed bit is set in the reference array.
    function automatic logic model_hit(input logic [H*PW-1:0] p);
        logic h;
        h = 1'b1;
        for (int i = 0; i < H; i++)
            if (!ref_mem[pword(p, i)][pbit(p, i)]) h = 1'b0;
        return h;
    endfunction

    // Query latency: full length, or first-zero index + 3 with early exit.
    function automatic int model_qlat(input logic [H*PW-1:0] p);
`ifdef BLOOM_EARLY_EXIT_EN
        for (int i = 0; i < H; i++)
            if (!ref_mem[pword(p, i)][pbit(p, i)]) return i + 3;
`endif
        return H + 2;
    endfunction

    // Call at a negedge; waits until the wanted ready is high (same cycle).
    task automatic wait_ready(input bit want_q, input bit want_i, output bit ok,
                              output bit got_q, output int waited);
        ok = 1'b0; got_q = 1'b0; waited = 0;
        for (int n = 0; n < 600; n++) begin
            #1;
            if ((want_q && bus.q_ready) || (want_i && bus.ins_ready)) begin
                ok = 1'b1; got_q = bus.q_ready; waited = n;
                return;
            end
            @(negedge clk);
        end
        check_eq("ready_timeout", 32'd0, 32'd1);
    endtask

    // Call just after the accept edge.
    task automatic wait_q_resp(input logic [H*PW-1:0] p, input string tag);
        int lat; int exp_lat; logic exp_hit;
        lat = 0; exp_hit = model_hit(p); exp_lat = model_qlat(p);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk); lat++;
            if (bus.q_resp_valid) break;
        end
        $display("query  %s probes=%h hit=%0d lat=%0d", tag, p, bus.q_hit, lat);
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_hit"}, 32'(bus.q_hit), 32'(exp_hit));
        @(negedge clk);
        check_eq({tag, "_pulse"}, 32'(bus.q_resp_valid), 32'd0);
    endtask

    task automatic wait_ins_done(input logic [H*PW-1:0] p, input string tag);
        int lat;
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk); lat++;
            if (bus.ins_done) break;
        end
        $display("insert %s probes=%h lat=%0d", tag, p, lat);
        check_eq({tag, "_lat"}, 32'(lat), 32'(2*H + 1));
        for (int i = 0; i < H; i++)
            ref_mem[pword(p, i)][pbit(p, i)] = 1'b1;
        for (int i = 0; i < H; i++)
            check_eq({tag, "_word"}, 32'(bram[pword(p, i)]), 32'(ref_mem[pword(p, i)]));
        @(negedge clk);
        check_eq({tag, "_pulse"}, 32'(bus.ins_done), 32'd0);
    endtask

    task automatic issue_query(input logic [H*PW-1:0] p, input string tag);
        bit ok; bit gq; int wt;
        @(negedge clk);
        bus.q_valid = 1'b1; bus.q_probes = p;
        wait_ready(1'b1, 1'b0, ok, gq, wt);
        if (ok) begin
            @(posedge clk); #1;
            bus.q_valid = 1'b0; bus.q_probes = rand_probes();
            wait_q_resp(p, tag);
        end else begin
            bus.q_valid = 1'b0;
        end
    endtask

    task automatic issue_insert(input logic [H*PW-1:0] p, input string tag, input bit clr_mid);
        bit ok; bit gq; int wt;
        @(negedge clk);
        bus.ins_valid = 1'b1; bus.ins_probes = p;
        wait_ready(1'b0, 1'b1, ok, gq, wt);
        if (ok) begin
            @(posedge clk); #1;
            bus.ins_valid = 1'b0; bus.ins_probes = rand_probes();
            if (clr_mid) bus.clr_req = 1'b1;
            wait_ins_done(p, tag);
        end else begin
            bus.ins_valid = 1'b0;
        end
    endtask

    // Waits for the sweep to start, then checks its length and result.
    task automatic wait_clear_sweep(input string tag);
        int st; int lat; int w0; int nz; bit rdy;
        st = 0; lat = 1; w0 = clr_writes; nz = 0; rdy = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk); st++;
            rdy |= bus.q_ready | bus.ins_ready;
            if (bus.clr_busy) break;
        end
        bus.clr_req = 1'b0;
        check_eq({tag, "_start"}, 32'(st), 32'd1);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk); lat++;
            rdy |= bus.q_ready | bus.ins_ready;
            if (bus.clr_done) break;
        end
        for (int a = 0; a < NW; a++) begin
            if (bram[a] != '0) nz++;
            ref_mem[a] = '0;
        end
        $display("clear  %s lat=%0d writes=%0d", tag, lat, clr_writes - w0);
        check_eq({tag, "_lat"}, 32'(lat), 32'(NW + 1));
        check_eq({tag, "_writes"}, 32'(clr_writes - w0), 32'(NW));
        check_eq({tag, "_nonzero"}, 32'(nz), 32'd0);
        check_eq({tag, "_ready_low"}, 32'(rdy), 32'd0);
        @(negedge clk);
        check_eq({tag, "_pulse"}, 32'(bus.clr_done), 32'd0);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        bus.clr_req = 1'b1;
        wait_clear_sweep(tag);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [H*PW-1:0] p1, p2, pq, pi;
        bit ok; bit gq; int wt;

        rst = 1'b1;
        bus.q_valid = 1'b0; bus.q_probes = '0;
        bus.ins_valid = 1'b0; bus.ins_probes = '0;
        bus.clr_req = 1'b0;
        for (int a = 0; a < NW; a++) bram[a] = DW'($urandom);

        // Reset state.
        repeat (2) @(negedge clk);
        check_eq("rst_outputs", 32'({bus.mem_en, bus.mem_we, |bus.mem_addr, |bus.mem_wdata,
                 bus.q_ready, bus.ins_ready, bus.q_resp_valid, bus.q_hit, bus.ins_done,
                 bus.clr_busy, bus.clr_done}), 32'd0);
        rst = 1'b0; #1;
        check_eq("rst_q_ready", 32'(bus.q_ready), 32'd1);
        check_eq("rst_ins_ready", 32'(bus.ins_ready), 32'd0);

        // Directed: clear, miss, insert, hit, duplicate-word insert.
        do_clear("clr0");
        p1 = mk3(5, 3, 17, 0, 200, 15);
        issue_query(p1, "q_miss");
        issue_insert(p1, "ins1", 1'b0);
        check_eq("w5",   32'(bram[5]),   32'h0008);
        check_eq("w17",  32'(bram[17]),  32'h0001);
        check_eq("w200", 32'(bram[200]), 32'h8000);
        issue_query(p1, "q_hit");
        p2 = mk3(9, 1, 9, 4, 9, 1);
        issue_insert(p2, "ins_dup", 1'b0);
        check_eq("w9", 32'(bram[9]), 32'h0012);

        // Both requesters held high: grants must alternate Q, I, Q, I.
        do_clear("clr1");
        pq = rand_probes();
        pi = rand_probes();
        @(negedge clk);
        bus.q_valid = 1'b1; bus.q_probes = pq;
        bus.ins_valid = 1'b1; bus.ins_probes = pi;
        for (int k = 0; k < 4; k++) begin
            wait_ready(1'b1, 1'b1, ok, gq, wt);
            if (!ok) break;
            check_eq("alt_grant", 32'(!gq), 32'(k % 2));
            check_eq("alt_one_ready", 32'(bus.q_ready & bus.ins_ready), 32'd0);
            if (k > 0) check_eq("alt_b2b_wait", 32'(wt), 32'd0);
            @(posedge clk);
            if (gq) wait_q_resp(pq, "alt_q");
            else    wait_ins_done(pi, "alt_i");
        end
        bus.q_valid = 1'b0; bus.ins_valid = 1'b0;

        // Clear requested while an insert is in flight.
        p1 = mk3(33, 7, 40, 2, 33, 9);
        issue_insert(p1, "ins_clr", 1'b1);
        check_eq("clr_idle_ready", 32'(bus.q_ready | bus.ins_ready), 32'd0);
        wait_clear_sweep("clr_mid");
        issue_query(p1, "q_after_clr");

        // Reset in the write cycle of an insert.
        @(negedge clk);
        bus.ins_valid = 1'b1; bus.ins_probes = mk3(60, 5, 61, 6, 62, 7);
        wait_ready(1'b0, 1'b1, ok, gq, wt);
        @(posedge clk); #1;
        bus.ins_valid = 1'b0;
        begin
            int d0;
            d0 = 0;
            repeat (2) @(negedge clk);
            check_eq("rstmid_we_before", 32'(bus.mem_we), 32'd1);
            rst = 1'b1; #1;
            check_eq("rstmid_outputs", 32'({bus.mem_en, bus.mem_we, |bus.mem_addr,
                     |bus.mem_wdata, bus.q_ready, bus.ins_ready, bus.q_resp_valid,
                     bus.ins_done, bus.clr_busy, bus.clr_done}), 32'd0);
            repeat (2) @(negedge clk);
            rst = 1'b0; #1;
            check_eq("rstmid_q_ready", 32'(bus.q_ready), 32'd1);
            check_eq("rstmid_ins_ready", 32'(bus.ins_ready), 32'd0);
            for (int n = 0; n < 10; n++) begin
                @(negedge clk);
                if (bus.ins_done) d0++;
            end
            $display("reset  mid-insert done_pulses=%0d", d0);
            check_eq("rstmid_no_done", 32'(d0), 32'd0);
        end
        do_clear("clr_post_rst");

        // Random mix checked against the reference array.
        for (int t = 0; t < 40; t++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0)     do_clear("rclr");
            else if (r < 9) issue_insert(rand_probes(), "rins", 1'b0);
            else            issue_query(rand_probes(), "rq");
        end

        check_eq("bus_idle_zero", 32'(bus_idle_viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bloom_probe_sched.md
# bloom_probe_sched

Shared-memory scheduler for the Bloom filter bit array. It arbitrates between a query requester, an insert requester and a clear engine, all using one single-port BRAM. Each accepted request is expanded into HASH_COUNT sequential probes. Queries do reads. Inserts do a read-modify-write per probe. Clear writes zero to every word. It sits between the hash stage, which supplies precomputed probe addresses, and the BRAM instance.

## Interface
- HASH_COUNT, 3, probes per request
- ADDR_WIDTH, 8, BRAM word address width
- DATA_WIDTH, 16, BRAM word width; BIT_W = $clog2(DATA_WIDTH)
- PW (derived), ADDR_WIDTH+BIT_W, probe width = {word_addr, bit_sel}

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- q_valid / q_ready  in/out  1  query handshake
- q_probes  in  HASH_COUNT*PW  probe i at [i*PW +: PW]
- q_resp_valid  out  1  one-cycle pulse, query finished
- q_hit  out  1  all probed bits set; valid only with q_resp_valid
- ins_valid / ins_ready  in/out  1  insert handshake
- ins_probes  in  HASH_COUNT*PW  same format as q_probes
- ins_done  out  1  one-cycle pulse, insert finished
- clr_req  in  1  level request to zero the whole array
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse at end of sweep
- mem_en, mem_we  out  1  BRAM enable and write enable
- mem_addr  out  ADDR_WIDTH  BRAM address
- mem_wdata  out  DATA_WIDTH  BRAM write data
- mem_rdata  in  DATA_WIDTH  read data; 1-cycle latency after a mem_en read

## Operation
- States: IDLE, Q_RD, Q_LAST, INS_RD, INS_WR, CLEAR, RESP.
- Reset values:
  - All outputs 0, state IDLE.
  - Probe index 0, clear counter 0.
  - rr_last = INSERT, so the query wins the first conflict.
- Arbitration happens only in IDLE, with priority in this order:
  - clr_req.
  - Query vs insert by round-robin, with rr_last updated on each grant.
- Readiness:
  - When only one of q_valid/ins_valid is set, that one is granted.
  - q_ready and ins_ready are high only in IDLE with clr_req low, and only for the port that would be granted.
- On accept, probes are captured into a register; inputs may change afterwards.
- Query sequence:
  - Q_RD issues read probe i each cycle for i = 0..HASH_COUNT-1, with bits pipelined.
  - Each cycle also samples rdata[bit_sel] of the previous probe.
  - Q_LAST samples the final probe. RESP drives q_resp_valid=1 and q_hit = AND of the sampled bits.
- Insert sequence, per probe:
  - INS_RD: read the word.
  - INS_WR: write mem_rdata | (1<<bit_sel).
  - After the last probe, RESP drives ins_done=1.
- Insert RMW is strictly sequential, so duplicate word addresses within one insert accumulate correctly.
- CLEAR:
  - Writes 0 to addresses 0..2^ADDR_WIDTH-1, one per cycle, with clr_busy high throughout.
  - clr_done pulses in the cycle after the last write, then the block returns to IDLE.
- When mem_en is low, mem_addr, mem_we and mem_wdata are 0.
- Reset mid-operation aborts immediately:
  - No response or done pulse is issued.
  - Array contents are unspecified; the host must clear after reset.

## Timing
- Latencies below are counted from the accept edge to the cycle in which the pulse is high.
- Query: HASH_COUNT+2 cycles (5 at default).
- Insert: 2*HASH_COUNT+1 cycles (7 at default).
- Clear: 2^ADDR_WIDTH+1 cycles to clr_done (257 at default).
- Back-to-back: a new accept is possible in the cycle after the RESP/clr_done cycle.
- Throughput is one request in flight at a time.
- A clr_req that arrives while a request is busy is serviced at the next IDLE, ahead of any pending request.

## Configuration
- BLOOM_EARLY_EXIT_EN defined:
  - A query ends at the first probe j whose bit reads 0.
  - q_resp_valid with q_hit=0 follows at j+3 cycles; the already-issued read of probe j+1 is discarded.
  - Hits keep full latency.
- BLOOM_EARLY_EXIT_EN undefined:
  - All probes are always read, giving constant query latency.
  - q_hit is still the AND of the bits.

## Structure
- bloom_pkg holds:
  - The state enum bloom_sched_state_t.
  - The grant enum {GNT_QUERY, GNT_INSERT}.
  - Default parameter constants.
  - The probe field-extract functions.
- Sub-module rr_arb2 is a 2-way round-robin arbiter with a registered last-grant and an update on accept.
- The top level holds the FSM, probe registers, hit accumulator and clear counter.

## Test plan
- Reset, clear, then query probes {(5,3),(17,0),(200,15)}: read, q_hit=0 at 5 cycles; with BLOOM_EARLY_EXIT_EN, at 3 cycles.
- Insert the same probes: ins_done at 7 cycles; words 5, 17 and 200 equal 0x0008, 0x0001 and 0x8000. A re-query gives q_hit=1.
- Insert with probes {(9,1),(9,4),(9,1)}: word 9 becomes 0x0012.
- q_valid and ins_valid held high together: grants alternate Q, I, Q, I, starting with the query.
- clr_req raised during an insert:
  - The insert completes with ins_done, then CLEAR runs for 256 writes and clr_done pulses.
  - Readiness stays low throughout, and a query afterwards returns q_hit=0.
- rst asserted in the INS_WR cycle: outputs 0 immediately, no ins_done, state IDLE, and q_ready=1 after deassertion.
